// File: rtl/aes128_iter_core.sv
// rtl/aes128_iter_core.sv - iterative AES-128 encryptor with UNROLL round stages per clock
// Round helpers (sub_byte, shift_rows, mix_columns, key_expansion, aes_round) precede the top.

module sub_byte (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // Byte b sits at bits [2047-8b -: 8]; 2047-8b is {~b, 3'b111}.
    assign y = SBOX[{~a, 3'b111} -: 8];
endmodule

module shift_rows (
    input  logic [127:0] a,
    output logic [127:0] y
);
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign y[127-8*(r+4*c) -: 8] = a[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end
endmodule

module mix_columns (
    input  logic [127:0] a,
    output logic [127:0] y
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = a[127-32*c -: 8];
        assign a1 = a[119-32*c -: 8];
        assign a2 = a[111-32*c -: 8];
        assign a3 = a[103-32*c -: 8];
        assign y[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        assign y[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        assign y[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        assign y[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
endmodule

module key_expansion (
    input  logic [3:0]   rnd,
    input  logic [127:0] prev_key,
    output logic [127:0] next_key
);
    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3, rot, sub, n0, n1, n2;

    always_comb begin
        rcon = 8'h00;
        case (rnd)
            4'd1:  rcon = 8'h01;
            4'd2:  rcon = 8'h02;
            4'd3:  rcon = 8'h04;
            4'd4:  rcon = 8'h08;
            4'd5:  rcon = 8'h10;
            4'd6:  rcon = 8'h20;
            4'd7:  rcon = 8'h40;
            4'd8:  rcon = 8'h80;
            4'd9:  rcon = 8'h1b;
            4'd10: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign {w0, w1, w2, w3} = prev_key;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        sub_byte u_sub (.a(rot[31-8*b -: 8]), .y(sub[31-8*b -: 8]));
    end

    assign n0 = w0 ^ sub ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign next_key = {n0, n1, n2, w3 ^ n2};
endmodule

module aes_round (
    input  logic [3:0]   rnd,
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    output logic [127:0] state_out,
    output logic [127:0] key_out
);
    logic [127:0] sb, sr, mc;

    for (genvar b = 0; b < 16; b++) begin : g_sb
        sub_byte u_sub (.a(state_in[127-8*b -: 8]), .y(sb[127-8*b -: 8]));
    end

    shift_rows    u_sr (.a(sb), .y(sr));
    mix_columns   u_mc (.a(sr), .y(mc));
    key_expansion u_ke (.rnd(rnd), .prev_key(key_in), .next_key(key_out));

    // The final round omits MixColumns.
    assign state_out = ((rnd == 4'd10) ? sr : mc) ^ key_out;
endmodule

module aes128_iter_core #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);
    localparam int CYCLES = 10 / UNROLL;

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
        $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, next_state;
    logic [127:0] data_reg, key_reg;
    logic [3:0]   rnd;
    logic         accept, advance, last_round;

    logic [127:0] stage_data [0:UNROLL];
    logic [127:0] stage_key  [0:UNROLL];
    logic [3:0]   stage_rnd  [0:UNROLL-1];

    assign stage_data[0] = data_reg;
    assign stage_key[0]  = key_reg;

    for (genvar i = 0; i < UNROLL; i++) begin : g_stage
        // Outside RUN the chain sees 1..UNROLL so key_expansion never gets an illegal index.
        assign stage_rnd[i] = (state == RUN) ? rnd + 4'(i) : 4'(i + 1);
        aes_round u_round (
            .rnd      (stage_rnd[i]),
            .state_in (stage_data[i]),
            .key_in   (stage_key[i]),
            .state_out(stage_data[i+1]),
            .key_out  (stage_key[i+1])
        );
    end

    assign last_round = (rnd == 4'(1 + (CYCLES - 1) * UNROLL));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        advance    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                advance = 1'b1;
                if (last_round) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept     = 1'b1;
                        next_state = RUN;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg   <= '0;
            key_reg    <= '0;
            rnd        <= '0;
            ciphertext <= '0;
        end else if (accept) begin
            data_reg <= plaintext ^ key;
            key_reg  <= key;
            rnd      <= 4'd1;
        end else if (advance) begin
            data_reg <= stage_data[UNROLL];
            key_reg  <= stage_key[UNROLL];
            rnd      <= last_round ? 4'd0 : rnd + 4'(UNROLL);
            if (last_round) ciphertext <= stage_data[UNROLL];
        end
    end
endmodule

// File: tb/tb_aes128_iter_core.sv
// tb/tb_aes128_iter_core.sv - scoreboard bench for aes128_iter_core at UNROLL 1, 2, 5 and 10

module tb_aes128_iter_core;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] plaintext, key;
    logic         in_valid   [4];
    logic         in_ready   [4];
    logic         out_valid  [4];
    logic         out_ready  [4];
    logic         busy       [4];
    logic [127:0] ciphertext [4];

    int           cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] sb_q [$];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        aes128_iter_core #(.UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .plaintext (plaintext),
            .key       (key),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .ciphertext(ciphertext[g]),
            .busy      (busy[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offers one pair, pushes its expected ciphertext, waits for out_valid and checks timing.
    task automatic run_block(input int d, input int lat, input logic [127:0] pt,
                             input logic [127:0] k, input logic [127:0] exp,
                             input bit scramble, input string tag);
        int n, nb;
        chk({tag, " in_ready before accept"}, 128'(in_ready[d]), 128'd1);
        plaintext   = pt;
        key         = k;
        in_valid[d] = 1'b1;
        sb_q.push_back(exp);
        step();
        in_valid[d] = 1'b0;
        n  = 0;
        nb = 0;
        while (!out_valid[d] && n < 40) begin
            if (busy[d]) nb++;
            if (scramble) begin
                plaintext = {$urandom, $urandom, $urandom, $urandom};
                key       = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'(lat));
        chk({tag, " busy cycles"}, 128'(nb), 128'(lat));
    endtask

    task automatic consume(input int d, input string tag);
        logic [127:0] exp;
        out_ready[d] = 1'b1;
        chk({tag, " out_valid before consume"}, 128'(out_valid[d]), 128'd1);
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard underflow"}, 128'd1, 128'd0);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, " ciphertext"}, ciphertext[d], exp);
        end
        step();
        chk({tag, " out_valid after consume"}, 128'(out_valid[d]), 128'd0);
        chk({tag, " in_ready after consume"}, 128'(in_ready[d]), 128'd1);
        out_ready[d] = 1'b0;
    endtask

    logic [127:0] b2b_pt [4];
    logic [127:0] b2b_ct [4];
    int           acc_cyc [4];

    initial begin
        b2b_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        b2b_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        b2b_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        b2b_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        b2b_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        b2b_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        b2b_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        b2b_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;

        rst       = 1'b1;
        plaintext = '0;
        key       = '0;
        for (int d = 0; d < 4; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end
        step();
        step();
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset out_valid d%0d", d), 128'(out_valid[d]), 128'd0);
            chk($sformatf("reset busy d%0d", d), 128'(busy[d]), 128'd0);
            chk($sformatf("reset in_ready d%0d", d), 128'(in_ready[d]), 128'd1);
            chk($sformatf("reset ciphertext d%0d", d), ciphertext[d], 128'd0);
        end

        // C.1 at UNROLL=1, then hold the result under backpressure for 20 cycles.
        run_block(0, 10, C1_PT, C1_KEY, C1_CT, 1'b0, "c1 u1");
        for (int i = 0; i < 20; i++) begin
            chk("bp ciphertext held", ciphertext[0], sb_q[0]);
            chk("bp out_valid held", 128'(out_valid[0]), 128'd1);
            chk("bp in_ready low", 128'(in_ready[0]), 128'd0);
            step();
        end
        consume(0, "bp release");

        run_block(1, 5, B_PT, B_KEY, B_CT, 1'b0, "fipsB u2");
        consume(1, "fipsB u2");
        run_block(2, 2, B_PT, B_KEY, B_CT, 1'b0, "fipsB u5");
        consume(2, "fipsB u5");
        run_block(3, 1, B_PT, B_KEY, B_CT, 1'b0, "fipsB u10");
        consume(3, "fipsB u10");

        // Back-to-back: in_valid held, out_ready tied high.
        begin
            int idx, na, guard;
            bit acc;
            idx          = 0;
            na           = 0;
            guard        = 0;
            out_ready[0] = 1'b1;
            key          = B_KEY;
            plaintext    = b2b_pt[0];
            in_valid[0]  = 1'b1;
            while ((na < 4 || sb_q.size() > 0) && guard < 100) begin
                acc = in_valid[0] && in_ready[0];
                if (out_valid[0]) begin
                    chk("b2b in_ready on consume", 128'(in_ready[0]), 128'd1);
                    if (sb_q.size() == 0) chk("b2b scoreboard underflow", 128'd1, 128'd0);
                    else chk("b2b ciphertext", ciphertext[0], sb_q.pop_front());
                end
                if (acc) begin
                    sb_q.push_back(b2b_ct[idx]);
                    acc_cyc[na] = cyc;
                    na++;
                end
                step();
                guard++;
                if (acc) begin
                    idx++;
                    if (idx < 4) plaintext = b2b_pt[idx];
                    else in_valid[0] = 1'b0;
                end
            end
            chk("b2b completed in budget", 128'(guard < 100), 128'd1);
            for (int i = 1; i < 4; i++)
                chk($sformatf("b2b spacing %0d", i), 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd11);
            out_ready[0] = 1'b0;
        end

        // Reset during the fifth RUN cycle discards the block.
        plaintext   = C1_PT;
        key         = C1_KEY;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("midrun busy before reset", 128'(busy[0]), 128'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun reset busy", 128'(busy[0]), 128'd0);
        chk("midrun reset out_valid", 128'(out_valid[0]), 128'd0);
        chk("midrun reset in_ready", 128'(in_ready[0]), 128'd1);
        run_block(0, 10, C1_PT, C1_KEY, C1_CT, 1'b0, "c1 after reset");
        consume(0, "c1 after reset");

        // Inputs scrambled every cycle after accept.
        run_block(0, 10, C1_PT, C1_KEY, C1_CT, 1'b1, "stability");
        consume(0, "stability");

        chk("scoreboard drained", 128'(sb_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes128_iter_core.md
Name: aes128_iter_core

Overview:
- Iterative AES-128 encryption engine with a valid/ready handshake on input and output.
- Reuses the existing per-round datapath pieces (key_expansion, sub_byte, shift_rows, mix_columns) inside a round loop.
- Generalises the single combinational round into a complete 10-round cipher with a parametrised unroll factor, correct final-round handling (no MixColumns) and output backpressure.
- Sits between the block-level data source and the ciphertext consumer.

Parameters:
- UNROLL, 1, rounds computed per clock. Legal values are 1, 2, 5 and 10. Any other value is an elaboration error.
- CYCLES, 10/UNROLL, derived as a localparam and not overridable. It is the number of RUN cycles per block.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext/key pair offered
- in_ready  out  1  core can accept a pair this cycle
- plaintext  in  128  input block, byte 0 in bits [127:120]
- key  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts the ciphertext
- ciphertext  out  128  result, same byte order
- busy  out  1  high in RUN

Behaviour:
- Reset: on a clk edge with rst=1:
  - state=IDLE; out_valid=0; busy=0; ciphertext=0.
  - Internal state register, round-key register and round counter are cleared.
  - in_ready is combinational and is 1 in IDLE.
- A reset mid-operation aborts the block silently. No output is produced for it.
- in_ready = (state==IDLE) or (state==DONE and out_ready).
- Input accept: occurs when in_valid and in_ready are both 1.
  - On accept: data_reg = plaintext XOR key (initial AddRoundKey); key_reg = key; rnd = 1; state goes to RUN.
  - plaintext and key are sampled only on accept and may change afterwards.
- RUN, each cycle:
  - UNROLL round stages are chained combinationally.
  - Stage i uses round index r = rnd + i, from 1 to 10.
  - Each stage applies SubBytes, ShiftRows, then MixColumns, except when r==10, where MixColumns is bypassed.
  - Each stage then XORs with the round key from key_expansion(r, previous round key).
  - The 4-bit round index maps to Rcon as 1→01, 2→02, 3→04, 4→08, 5→10, 6→20, 7→40, 8→80, 9→1b, 10→36.
  - At the end of the cycle, data_reg and key_reg take the last stage outputs and rnd += UNROLL.
- RUN→DONE: on the cycle whose final stage is r==10.
  - ciphertext is registered in that same cycle and out_valid=1.
  - Latency: out_valid rises exactly CYCLES clocks after the accept edge. For UNROLL=1 this is 10; for UNROLL=10 it is 1.
- DONE:
  - ciphertext and out_valid are held stable while out_ready=0, for unbounded time.
  - out_ready=1 and in_valid=0: the result is consumed, out_valid goes to 0 and state goes to IDLE.
  - out_ready=1 and in_valid=1: the result is consumed and the new pair is accepted in the same cycle. out_valid drops to 0 and state goes to RUN. No bubble cycle.
- Throughput: one block per CYCLES+1 clocks with out_ready tied high.
- in_valid while busy is ignored (in_ready=0). The source must hold the pair, per standard valid/ready rules.
- busy=1 exactly in RUN.
- The rnd counter never exceeds 10. Round indices 0 and 11–15 are never presented to key_expansion.
- X-free: out_valid and in_ready are never X after the first reset.

Test Plan:
- FIPS-197 C.1, UNROLL=1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid exactly 10 clocks after accept; busy high for 10 cycles.
- FIPS-197 B vector, repeated for UNROLL=2, 5 and 10: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. Latency must be 5, 2 and 1 clocks respectively.
- Backpressure: out_ready=0 for 20 cycles after out_valid. The ciphertext must stay constant and in_ready=0 throughout. Then drive out_ready=1 with in_valid=0: out_valid drops the next cycle and in_ready goes to 1.
- Back-to-back: out_ready tied 1, in_valid held with 4 different vectors.
  - Each new block must be accepted on the same edge the previous result is consumed.
  - Spacing must be 11 clocks per block (UNROLL=1), and every result must match the golden model.
- Reset mid-run: assert rst for 1 cycle at RUN cycle 5. Next cycle: state IDLE, out_valid=0, busy=0, in_ready=1. A subsequent C.1 vector must still produce 69c4e0d8…c55a.
- Input stability: change plaintext and key every cycle after accept. The result must equal the encryption of the values sampled at accept.
